// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default sizes, write-arbiter owner
// encodings and the FIFO state encodings used across benches.
package fifo_pkg;

  localparam int FIFO_DEPTH      = 8;
  localparam int FIFO_CNT_WIDTH  = 4;
  localparam int FIFO_DATA_WIDTH = 32;

  localparam logic OWN0 = 1'b0;
  localparam logic OWN1 = 1'b1;

  localparam logic [2:0] INIT     = 3'd0;
  localparam logic [2:0] NO_OP    = 3'd1;
  localparam logic [2:0] WRITE    = 3'd2;
  localparam logic [2:0] WR_ERROR = 3'd3;
  localparam logic [2:0] READ     = 3'd4;
  localparam logic [2:0] RD_ERROR = 3'd5;

endpackage

// File: rtl/fifo_wr_arb_pick.sv
// Combinational winner selection for the FIFO write arbiter.
// In: req0/req1, owner, burst, space_ok. Out: gnt0/gnt1, hit_own/hit_oth.
module fifo_wr_arb_pick
  import fifo_pkg::*;
#(
  parameter int MAX_BURST   = 4,
  parameter int BURST_WIDTH = 3
) (
  input  logic                   req0,
  input  logic                   req1,
  input  logic                   owner,
  input  logic [BURST_WIDTH-1:0] burst,
  input  logic                   space_ok,
  output logic                   gnt0,
  output logic                   gnt1,
  output logic                   hit_own,
  output logic                   hit_oth
);

  logic req_own;
  logic req_oth;
  logic under;
  logic win;

  assign req_own = (owner == OWN1) ? req1 : req0;
  assign req_oth = (owner == OWN1) ? req0 : req1;
  assign under   = burst < BURST_WIDTH'(MAX_BURST);

  always_comb begin
    hit_own = 1'b0;
    hit_oth = 1'b0;
    priority case (1'b1)
      !space_ok: ;
      req_own && (under || !req_oth): hit_own = 1'b1;
      req_oth: hit_oth = 1'b1;
      default: ;
    endcase
  end

  // The winner is the owner on a sticky hit, else the other side.
  assign win  = hit_own ? owner : ~owner;
  assign gnt0 = (hit_own || hit_oth) && (win == OWN0);
  assign gnt1 = (hit_own || hit_oth) && (win == OWN1);

endmodule

// File: rtl/fifo_wr_arb.sv
// Two-requester owner-sticky write arbiter for the 8-deep FIFO.
// In: clk, reset_n, req0/1, din0/1, data_count.
// Out: gnt0/1, wr_en, wr_data, full_stall.
module fifo_wr_arb
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = FIFO_DATA_WIDTH,
  parameter int DEPTH       = FIFO_DEPTH,
  parameter int CNT_WIDTH   = FIFO_CNT_WIDTH,
  parameter int MAX_BURST   = 4,
  parameter int BURST_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req0,
  input  logic [DATA_WIDTH-1:0] din0,
  input  logic                  req1,
  input  logic [DATA_WIDTH-1:0] din1,
  output logic                  gnt0,
  output logic                  gnt1,
  input  logic [CNT_WIDTH-1:0]  data_count,
  output logic                  wr_en,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full_stall
);

  localparam int SW = CNT_WIDTH + 1;

  logic                   owner_q, owner_d;
  logic [BURST_WIDTH-1:0] burst_q, burst_d;
  logic                   wr_en_q, wr_en_d;
  logic [DATA_WIDTH-1:0]  wr_data_q, wr_data_d;

  logic [SW-1:0] used;
  logic [SW-1:0] space;
  logic          space_ok;
  logic          hit_own;
  logic          hit_oth;

  // The in-flight write is not yet in data_count; count it as used.
  // An out-of-range data_count also lands in the zero-space branch.
  assign used  = {1'b0, data_count} + {{CNT_WIDTH{1'b0}}, wr_en_q};
  assign space = (used >= SW'(DEPTH)) ? '0 : SW'(DEPTH) - used;

  // Gating with reset_n keeps grants low while reset is held.
  assign space_ok   = reset_n && (space != '0);
  assign full_stall = (req0 || req1) && (space == '0);

  fifo_wr_arb_pick #(
    .MAX_BURST  (MAX_BURST),
    .BURST_WIDTH(BURST_WIDTH)
  ) u_pick (
    .req0    (req0),
    .req1    (req1),
    .owner   (owner_q),
    .burst   (burst_q),
    .space_ok(space_ok),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .hit_own (hit_own),
    .hit_oth (hit_oth)
  );

  always_comb begin
    owner_d   = owner_q;
    burst_d   = '0;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    if (hit_own) begin
      if (burst_q < BURST_WIDTH'(MAX_BURST))
        burst_d = burst_q + 1'b1;
      else
        burst_d = burst_q;
    end else if (hit_oth) begin
      owner_d = ~owner_q;
      burst_d = BURST_WIDTH'(1);
    end
    if (gnt0 || gnt1) begin
      wr_en_d   = 1'b1;
      wr_data_d = gnt1 ? din1 : din0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_q   <= OWN0;
      burst_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
    end else begin
      owner_q   <= owner_d;
      burst_q   <= burst_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_data = wr_data_q;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Randomized and directed bench for fifo_wr_arb with a FIFO
// occupancy model and a rule-level arbitration reference.
module tb_fifo_wr_arb;

  localparam int MAXB = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [31:0] din0 = '0, din1 = '0;
  logic        gnt0, gnt1;
  logic [3:0]  data_count;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        full_stall;

  logic        rd = 1'b0;
  logic        fifo_clr = 1'b0;
  logic [3:0]  cnt = '0;
  int          overflow = 0;

  int checks = 0;
  int errors = 0;

  // reference model state
  int   m_owner = 0;
  int   m_streak = 0;
  bit   m_we = 0;
  logic [31:0] m_wd = '0;
  int   m_win = -1;
  bit   e_g0, e_g1, e_st, e_we;
  logic [31:0] e_wd;

  always #5 clk = ~clk;

  fifo_wr_arb dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req0      (req0),
    .din0      (din0),
    .req1      (req1),
    .din1      (din1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .data_count(data_count),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full_stall(full_stall)
  );

  assign data_count = cnt;

  // FIFO occupancy: one write and one read per cycle at most.
  always @(posedge clk) begin
    if (fifo_clr) cnt <= '0;
    else begin
      if (wr_en && cnt == 4'd8) overflow <= overflow + 1;
      cnt <= cnt + {3'b0, wr_en && cnt != 4'd8}
                 - {3'b0, rd && cnt != 4'd0};
    end
  end

  task automatic model_reset();
    m_owner = 0; m_streak = 0; m_we = 0; m_wd = '0; m_win = -1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; fifo_clr = 1'b1;
    req0 = 0; req1 = 0; rd = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1; fifo_clr = 1'b0;
    model_reset();
  endtask

  // Drive one cycle and derive expectations from the arbitration rules.
  task automatic drive(input bit r0, input bit r1, input bit rdv);
    int sp, own_r, oth_r;
    @(negedge clk);
    req0 = r0; req1 = r1; rd = rdv;
    din0 = $urandom; din1 = $urandom;
    #1;
    sp = 8 - int'(cnt) - int'(m_we);
    if (sp < 0) sp = 0;
    own_r = (m_owner == 1) ? r1 : r0;
    oth_r = (m_owner == 1) ? r0 : r1;
    if (sp == 0) m_win = -1;
    else if (own_r != 0 && (m_streak < MAXB || oth_r == 0))
      m_win = m_owner;
    else if (oth_r != 0) m_win = 1 - m_owner;
    else m_win = -1;
    e_g0 = (m_win == 0);
    e_g1 = (m_win == 1);
    e_st = (r0 || r1) && sp == 0;
    e_we = m_we;
    e_wd = m_wd;
  endtask

  task automatic commit();
    if (m_win < 0) m_streak = 0;
    else if (m_win == m_owner) m_streak++;
    else begin m_owner = m_win; m_streak = 1; end
    m_we = (m_win >= 0);
    if (m_win == 0) m_wd = din0;
    else if (m_win == 1) m_wd = din1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req0 = 1; req1 = 1;
    @(negedge clk);
    checks++;
    if ({gnt0, gnt1, wr_en} !== 3'b000 || wr_data !== 32'h0) begin
      errors++;
      $display("FAIL reset g0g1we=%b wd=%h want 000/0",
               {gnt0, gnt1, wr_en}, wr_data);
    end
    do_reset();
  endtask

  task automatic test_fill();
    int ng = 0;
    for (int i = 0; i < 12; i++) begin
      drive(1, 0, 0);
      checks++;
      if ({gnt0, gnt1, full_stall, wr_en} !== {e_g0, e_g1, e_st, e_we}) begin
        errors++;
        $display("FAIL fill_ctl cyc %0d got %b want %b", i,
                 {gnt0, gnt1, full_stall, wr_en}, {e_g0, e_g1, e_st, e_we});
      end
      if (e_we) begin
        checks++;
        if (wr_data !== e_wd) begin
          errors++;
          $display("FAIL fill_data got %h want %h", wr_data, e_wd);
        end
      end
      if (gnt0) ng++;
      commit();
    end
    checks++;
    if (ng != 8 || full_stall !== 1'b1 || data_count !== 4'd8) begin
      errors++;
      $display("FAIL fill_end grants %0d stall %b dc %0d want 8/1/8",
               ng, full_stall, data_count);
    end
  endtask

  task automatic test_fairness();
    int exp_seq[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(1, 1, 1);
      checks++;
      if ({gnt0, gnt1} !== (exp_seq[i] == 0 ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL fair_seq idx %0d got %b want gnt%0d", i,
                 {gnt0, gnt1}, exp_seq[i]);
      end
      if (e_we) begin
        checks++;
        if (wr_en !== 1'b1 || wr_data !== e_wd) begin
          errors++;
          $display("FAIL fair_data got %b/%h want 1/%h",
                   wr_en, wr_data, e_wd);
        end
      end
      commit();
    end
  endtask

  task automatic test_inflight();
    bit found = 0;
    do_reset();
    for (int i = 0; i < 20 && !found; i++) begin
      drive(1, 0, 0);
      if (data_count == 4'd7 && wr_en) begin
        found = 1;
        checks++;
        if (gnt0 !== 1'b0 || full_stall !== 1'b1) begin
          errors++;
          $display("FAIL inflight_stall got g0 %b st %b want 0/1",
                   gnt0, full_stall);
        end
      end
      commit();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL inflight_timeout got none want dc7+wr_en");
    end
    drive(1, 0, 1);
    commit();
    drive(1, 0, 0);
    checks++;
    if (data_count !== 4'd7 || wr_en !== 1'b0 || gnt0 !== 1'b1) begin
      errors++;
      $display("FAIL inflight_regrant dc %0d we %b g0 %b want 7/0/1",
               data_count, wr_en, gnt0);
    end
    commit();
  endtask

  task automatic test_late_arrival();
    bit r0v[5] = '{0, 0, 1, 1, 1};
    logic [1:0] want[5] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(r0v[i], 1, 1);
      checks++;
      if ({gnt0, gnt1} !== want[i]) begin
        errors++;
        $display("FAIL late idx %0d got %b want %b", i,
                 {gnt0, gnt1}, want[i]);
      end
      commit();
    end
  endtask

  task automatic test_idle_burst();
    bit r0v[9] = '{1, 1, 1, 0, 1, 1, 1, 1, 1};
    bit r1v[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 1};
    logic [1:0] want[9] = '{2'b10, 2'b10, 2'b10, 2'b00,
                            2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(r0v[i], r1v[i], 1);
      checks++;
      if ({gnt0, gnt1} !== want[i]) begin
        errors++;
        $display("FAIL idle idx %0d got %b want %b", i,
                 {gnt0, gnt1}, want[i]);
      end
      commit();
    end
  endtask

  task automatic test_random();
    int bad = 0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 2) == 0);
      checks++;
      if ({gnt0, gnt1, full_stall, wr_en} !== {e_g0, e_g1, e_st, e_we}) begin
        errors++;
        if (bad++ < 10)
          $display("FAIL rand_ctl cyc %0d got %b want %b", i,
                   {gnt0, gnt1, full_stall, wr_en},
                   {e_g0, e_g1, e_st, e_we});
      end
      if (e_we) begin
        checks++;
        if (wr_data !== e_wd) begin
          errors++;
          if (bad++ < 10)
            $display("FAIL rand_data cyc %0d got %h want %h",
                     i, wr_data, e_wd);
        end
      end
      commit();
    end
  endtask

  task automatic test_reset_mid();
    bit saw_we = 0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 1);
      commit();
    end
    drive(1, 1, 1);
    saw_we = wr_en;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (!saw_we || {gnt0, gnt1, wr_en} !== 3'b000 || wr_data !== '0) begin
      errors++;
      $display("FAIL reset_mid pre_we %b g0g1we %b wd %h want 1/000/0",
               saw_we, {gnt0, gnt1, wr_en}, wr_data);
    end
    model_reset();
    req0 = 0; req1 = 0;
    @(negedge clk);
    reset_n = 1'b1;
    drive(1, 1, 1);
    checks++;
    if ({gnt0, gnt1} !== 2'b10) begin
      errors++;
      $display("FAIL reset_first got %b want 10", {gnt0, gnt1});
    end
    commit();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_fairness();
    test_inflight();
    test_late_arrival();
    test_idle_burst();
    test_random();
    test_reset_mid();
    @(negedge clk);
    checks++;
    if (overflow !== 0) begin
      errors++;
      $display("FAIL overflow got %0d want 0", overflow);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arb.md
Name: fifo_wr_arb

Overview:
- Two-requester write arbiter that shares the single write port of the 8-deep FIFO.
- Owner-sticky arbitration with a burst limit: the current owner keeps the port for up to MAX_BURST consecutive grants, then yields if the other requester is waiting.
- Uses the FIFO's data_count plus its own in-flight write to guarantee the FIFO is never written when full, so the FIFO's write-error condition is unreachable through this block.
- Sits between two producers and the FIFO's wr_en/din inputs.

Parameters:
- DATA_WIDTH, 32, width of the write data path.
- DEPTH, 8, FIFO capacity in entries; must match the FIFO.
- CNT_WIDTH, 4, width of data_count; holds 0..DEPTH.
- MAX_BURST, 4, maximum consecutive grants to one owner while the other requests; range 1..7.
- BURST_WIDTH, 3, width of the burst counter; holds 0..MAX_BURST.

Ports:
- clk, input, 1, single clock; all state updates on its rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- req0, input, 1, requester 0 has a word to write; level signal, held until granted.
- din0, input, DATA_WIDTH, requester 0 write data; valid while req0=1.
- req1, input, 1, requester 1 request, same rules as req0.
- din1, input, DATA_WIDTH, requester 1 write data.
- gnt0, output, 1, combinational; transfer from requester 0 occurs in any cycle where req0 && gnt0.
- gnt1, output, 1, combinational; same rule for requester 1.
- data_count, input, CNT_WIDTH, FIFO occupancy; registered inside the FIFO and reflects writes up to the previous cycle.
- wr_en, output, 1, registered FIFO write enable.
- wr_data, output, DATA_WIDTH, registered FIFO write data.
- full_stall, output, 1, combinational; 1 when (req0 || req1) and space==0.

Behaviour:
- Reset (async, reset_n=0):
  - wr_en=0, wr_data=0.
  - owner=0, burst=0.
  - gnt0/gnt1 are 0 during reset regardless of req.
- Space calculation:
  - space = DEPTH - data_count - wr_en, computed at CNT_WIDTH+1 bits.
  - At most one write is ever in flight: a grant at cycle t gives wr_en at t+1, and data_count updates at t+2.
  - Grants are permitted only when space > 0.
  - Reads freeing space are seen only via data_count (conservative). No same-cycle read credit.
- Winner selection (other = !owner):
  - space==0: no winner.
  - Else if req_owner && (burst < MAX_BURST || !req_other): winner = owner.
  - Else if req_other: winner = other.
  - Else: no winner.
  - gnt0 = (winner is 0), gnt1 = (winner is 1). Never both high.
- Next-state rules:
  - Winner == owner: burst = min(burst+1, MAX_BURST). Saturates only when the other is idle.
  - Winner == other: owner = other, burst = 1.
  - No winner: owner holds, burst = 0.
  - Any grant: wr_en <= 1, wr_data <= din of the winner.
  - No grant: wr_en <= 0; wr_data holds its previous value.
- Latency: request to FIFO write is 1 cycle. Sustained throughput is 1 word per cycle while space allows.
- Full boundary:
  - data_count=7 with wr_en=1 gives space=0, so no grant.
  - data_count=8 gives no grant.
  - The FIFO never sees wr_en while full.
- Requester drop: a request deasserted mid-burst is not an error. Arbitration re-evaluates every cycle.
- Reset mid-operation: any in-flight wr_en is cleared immediately, and the pending word is lost. Producers must re-request after reset.
- data_count > DEPTH is illegal input; the block treats it as space=0.

Decomposition:
- Shared package fifo_pkg holds:
  - DEPTH, CNT_WIDTH, DATA_WIDTH defaults.
  - Owner encodings: OWN0=1'b0, OWN1=1'b1.
  - The FIFO state encodings INIT/NO_OP/WRITE/WR_ERROR/READ/RD_ERROR, so that benches share one definition.
- One natural sub-module, fifo_wr_arb_pick: purely combinational winner/grant selection from (req0, req1, owner, burst, space). The top level holds the registers and the space computation.

Test Plan:
- Single requester fill: req0=1 continuously from empty, req1=0, no reads.
  - gnt0 high for 8 cycles; wr_en high 8 cycles, each one cycle after its grant.
  - Then gnt0=0 and full_stall=1 with data_count=8. No wr_en while full.
- Burst fairness: both requesters held high, FIFO drained every cycle so space stays >0.
  - Grant sequence is 0,0,0,0,1,1,1,1,0,...
  - wr_data follows din with 1-cycle lag.
- In-flight accounting: data_count=7 and wr_en=1 in the same cycle.
  - No grant that cycle; full_stall=1 if a request is present.
  - After a read drops data_count to 7 with wr_en=0, a grant issues that cycle.
- Late arrival: req1 alone for 2 grants (owner=1, burst=2), then req0 rises.
  - Requester 1 gets 2 more grants, then ownership switches to 0 with burst=1.
- Idle resets burst: owner 0 has 3 grants, then neither requester asserts for 1 cycle, then both request.
  - Owner 0 gets a fresh 4-grant burst.
- Reset mid-burst: assert reset_n=0 asynchronously while wr_en=1.
  - wr_en=0, wr_data=0, gnt0=gnt1=0 immediately.
  - After release with both requesting, requester 0 wins first.
